f_edge_monitor: RTL
===================

// Module: f_edge_monitor
// PURPOSE
//  Downstream consumer of the sel1/sel2 structural demo's combinational output f.
//  Synchronises f into clk, then counts rising edges, falling edges and high cycles
//  over a programmable window of clk cycles.
//  Results are presented through a valid/ready report handshake to the next stage.
// PARAMETERS
//  CNT_W        8   width of the rise/fall edge counters (saturating)
//  WIN_W        16  width of window length and high-cycle counter (saturating)
//  SYNC_STAGES  2   flop stages in the f_in synchroniser (>=2)
// PORTS
//  clk        in   1      system clock, all logic on posedge
//  rst_n      in   1      asynchronous active-low reset
//  f_in       in   1      f from the demo stage; asynchronous to clk
//  start      in   1      begin a measurement window (honoured only in IDLE)
//  win_len    in   WIN_W  window length in clk cycles, captured on accepted start
//  rpt_ready  in   1      consumer accepts the report
//  busy       out  1      high in MEASURE and REPORT
//  rpt_valid  out  1      report fields valid
//  rise_cnt   out  CNT_W  0->1 transitions of f_sync in the window
//  fall_cnt   out  CNT_W  1->0 transitions of f_sync in the window
//  high_cnt   out  WIN_W  cycles with f_sync==1 in the window
//  f_sync     out  1      synchronised f (last synchroniser stage)
// BEHAVIOUR
//  Reset: every output and all internal state 0; FSM=IDLE. Applies immediately (async).
//  Synchroniser: f_sync follows f_in after SYNC_STAGES clk edges. Reset clears the chain to 0.
//  FSM states: IDLE, MEASURE, REPORT.
//   IDLE: busy=0, rpt_valid=0.
//    start=1 -> clear counters, load win_left=win_len, load f_prev=f_sync.
//    Then -> MEASURE, or -> REPORT directly if win_len==0 (all counts 0).
//   MEASURE: busy=1. Each cycle:
//    f_sync&~f_prev -> rise_cnt+1; ~f_sync&f_prev -> fall_cnt+1.
//    f_sync -> high_cnt+1. f_prev<=f_sync. win_left-1.
//    Exactly win_len cycles are sampled, including the cycle after entry.
//    The cycle with win_left==1 is the last sample -> REPORT.
//   REPORT: busy=1, rpt_valid=1. rise_cnt/fall_cnt/high_cnt are held stable.
//    rpt_valid & rpt_ready on the same edge -> IDLE; counts are retained until the next start.
//    rpt_valid is never dropped before that handshake.
//  No spurious edge at window start: f_prev is seeded from f_sync, not from 0.
//  Counters saturate at all-ones and never wrap.
//  start outside IDLE is ignored, including start in the handshake cycle.
//  win_len is sampled only on the accepted start; later changes have no effect.
//  rst_n low mid-window or mid-report: abort, all outputs 0, state IDLE.
//  rpt_ready while not in REPORT has no effect.
// STRUCTURE
//  Shared package (ex_pkg): FSM state encoding localparams
//  (ST_IDLE=2'd0, ST_MEAS=2'd1, ST_RPT=2'd2) and default widths CNT_W/WIN_W.
//  One sub-module: sync_ff (parameterised SYNC_STAGES-deep single-bit synchroniser, async
//  active-low reset). Edge detect, counters and FSM live in f_edge_monitor.
// TESTING
//  1 rst_n=0 with f_in toggling -> all outputs 0.
//    Release reset, f_in=1 -> f_sync=1 exactly 2 clk edges later.
//  2 f_in=1 held, start with win_len=10 -> after 10 MEAS cycles rpt_valid=1:
//    rise=0, fall=0, high=10. rpt_ready=1 -> IDLE, busy=0 next cycle.
//  3 f_in square wave, 4 cycles high/4 low, f_sync=0 at start, win_len=16
//    -> rise=2, fall=2, high=8.
//  4 win_len=0 -> rpt_valid the cycle after start, all counts 0.
//    Hold rpt_ready=0 for 5 cycles -> rpt_valid and counts stay constant.
//  5 CNT_W=2, f_in toggled every cycle, win_len=20 -> rise_cnt=3, fall_cnt=3 (saturated).
//    A start pulse during MEASURE is ignored and does not reload win_left.
//  6 rst_n pulsed low mid-MEASURE -> busy=0, counts 0, IDLE.
//    A new start with win_len=4 then completes normally.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared definitions for the f edge monitor.
//   state_t     : monitor FSM state encoding
//   DEF_CNT_W   : default width of the rise/fall edge counters
//   DEF_WIN_W   : default width of the window length and high-cycle counter
package ex_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MEAS = 2'd1,
      ST_RPT  = 2'd2
   } state_t;

   localparam int DEF_CNT_W = 8;
   localparam int DEF_WIN_W = 16;

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchroniser for a signal asynchronous to clk.
//   clk   : sampling clock
//   rst_n : asynchronous active-low reset, clears the whole chain
//   d     : asynchronous input
//   q     : synchronised output, d delayed by STAGES clk edges
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/f_edge_monitor.sv
// Measures the synchronised f signal over a programmable window of clk cycles:
// rising edges, falling edges and high cycles, reported via valid/ready.
//   clk, rst_n          : clock, asynchronous active-low reset
//   f_in                : f from the demo stage, asynchronous to clk
//   start, win_len      : start a window of win_len cycles (accepted in IDLE only)
//   rpt_ready           : consumer accepts the report
//   busy, rpt_valid     : status / report valid
//   rise_cnt, fall_cnt  : saturating edge counts
//   high_cnt            : saturating count of cycles with f_sync high
//   f_sync              : synchronised f
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for start, last report's counts still visible
// ST_MEAS | sampling f_sync once per cycle, win_left cycles to go
// ST_RPT  | counts frozen, rpt_valid held until rpt_ready
module f_edge_monitor
   import ex_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int WIN_W       = DEF_WIN_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             f_in,
   input  logic             start,
   input  logic [WIN_W-1:0] win_len,
   input  logic             rpt_ready,
   output logic             busy,
   output logic             rpt_valid,
   output logic [CNT_W-1:0] rise_cnt,
   output logic [CNT_W-1:0] fall_cnt,
   output logic [WIN_W-1:0] high_cnt,
   output logic             f_sync
);

   state_t           state;
   state_t           state_nxt;
   logic [WIN_W-1:0] win_left;
   logic             f_prev;
   logic             accept;

   sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (f_in),
      .q     (f_sync)
   );

   assign accept = (state == ST_IDLE) && start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      rpt_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = (win_len == '0) ? ST_RPT : ST_MEAS;
            end
         end
         ST_MEAS: begin
            busy = 1'b1;
            if (win_left == WIN_W'(1)) begin
               state_nxt = ST_RPT;
            end
         end
         ST_RPT: begin
            busy      = 1'b1;
            rpt_valid = 1'b1;
            if (rpt_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // f_prev is seeded from f_sync on start so a window opening while f is
   // already high does not count a phantom rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_left <= '0;
         f_prev   <= 1'b0;
         rise_cnt <= '0;
         fall_cnt <= '0;
         high_cnt <= '0;
      end else if (accept) begin
         win_left <= win_len;
         f_prev   <= f_sync;
         rise_cnt <= '0;
         fall_cnt <= '0;
         high_cnt <= '0;
      end else if (state == ST_MEAS) begin
         if (f_sync && !f_prev && (rise_cnt != '1)) begin
            rise_cnt <= rise_cnt + 1'b1;
         end
         if (!f_sync && f_prev && (fall_cnt != '1)) begin
            fall_cnt <= fall_cnt + 1'b1;
         end
         if (f_sync && (high_cnt != '1)) begin
            high_cnt <= high_cnt + 1'b1;
         end
         f_prev   <= f_sync;
         win_left <= win_left - 1'b1;
      end
   end

endmodule
